// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/adjust sequencer and digit scan.
// Optional lap hold feature: define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned SCAN_DIV  = 250000,
    parameter int unsigned BLINK_DIV = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       clr_btn,
    input  logic       lap_btn,
    input  logic       sw_adjust,
    input  logic       sw_sel,
    output logic       cnt_inc,
    output logic [1:0] cnt_field,
    output logic       cnt_clr,
    output logic       running,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic       disp_hold
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_PAUSED,
        S_ADJ_SEC,
        S_ADJ_MIN
    } state_t;

    state_t        state, state_n;
    logic          resume, resume_n;
    logic          blink_phase, blink_n;
    logic [SW-1:0] scan_cnt, scan_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          pause_prev, clr_prev;
    logic          pause_edge, clr_edge;
    logic          in_adj, enter_adj;
    logic          inc_n;
    logic [1:0]    field_n;
    logic [1:0]    dig_n;
    logic          blanked;
    logic [3:0]    an_n;
    logic          hold_n;

    assign pause_edge = pause_btn & ~pause_prev;
    assign clr_edge   = clr_btn & ~clr_prev;
    assign in_adj     = (state == S_ADJ_SEC) || (state == S_ADJ_MIN);
    assign enter_adj  = !in_adj &&
                        ((state_n == S_ADJ_SEC) || (state_n == S_ADJ_MIN));

    // Mode transitions: clear beats adjust beats pause.
    always_comb begin
        state_n  = state;
        resume_n = resume;
        if (clr_edge) begin
            state_n  = S_PAUSED;
            resume_n = 1'b0;
        end else if (sw_adjust) begin
            if (!in_adj) resume_n = (state == S_RUN);
            state_n = sw_sel ? S_ADJ_SEC : S_ADJ_MIN;
        end else if (in_adj) begin
            state_n = resume ? S_RUN : S_PAUSED;
        end else if (pause_edge) begin
            state_n = (state == S_RUN) ? S_PAUSED : S_RUN;
        end
    end

    // Increment strobe follows the current mode; a clear drops the tick.
    always_comb begin
        inc_n   = 1'b0;
        field_n = cnt_field;
        unique case (state)
            S_RUN: if (tick_1hz) begin
                inc_n   = 1'b1;
                field_n = 2'b00;
            end
            S_ADJ_SEC: if (tick_2hz) begin
                inc_n   = 1'b1;
                field_n = 2'b01;
            end
            S_ADJ_MIN: if (tick_2hz) begin
                inc_n   = 1'b1;
                field_n = 2'b10;
            end
            default: ;
        endcase
        if (clr_edge) begin
            inc_n   = 1'b0;
            field_n = cnt_field;
        end
    end

    // Scan and blink timebases; anodes use the updated digit and mode.
    always_comb begin
        scan_n      = scan_cnt + SW'(1);
        dig_n       = digit_sel;
        blink_cnt_n = blink_cnt + BW'(1);
        blink_n     = blink_phase;
        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_n = '0;
            dig_n  = digit_sel + 2'd1;
        end
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt_n = '0;
            blink_n     = ~blink_phase;
        end
        blanked = 1'b0;
        if (!blink_n) begin
            if (state_n == S_ADJ_SEC) blanked = !dig_n[1];
            if (state_n == S_ADJ_MIN) blanked = dig_n[1];
        end
        an_n = blanked ? 4'b1111 : ~(4'b0001 << dig_n);
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_prev;
    logic lap_edge;
    assign lap_edge = lap_btn & ~lap_prev;

    // Lap toggles the display hold; clear or entering adjust releases it.
    always_comb begin
        hold_n = disp_hold ^ lap_edge;
        if (clr_edge || enter_adj) hold_n = 1'b0;
    end

    // Lap button edge-detect register.
    always_ff @(posedge clk) begin
        lap_prev <= lap_btn;
    end
`else
    logic lap_unused;
    logic adj_unused;
    assign lap_unused = lap_btn;
    assign adj_unused = enter_adj;

    // Without the lap feature the display never holds.
    always_comb begin
        hold_n = 1'b0;
    end
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        pause_prev <= pause_btn;
        clr_prev   <= clr_btn;
        if (rst) begin
            state       <= S_PAUSED;
            resume      <= 1'b0;
            blink_phase <= 1'b1;
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            cnt_inc     <= 1'b0;
            cnt_field   <= 2'b00;
            cnt_clr     <= 1'b0;
            running     <= 1'b0;
            digit_sel   <= 2'd0;
            an          <= 4'b1111;
            disp_hold   <= 1'b0;
        end else begin
            state       <= state_n;
            resume      <= resume_n;
            blink_phase <= blink_n;
            scan_cnt    <= scan_n;
            blink_cnt   <= blink_cnt_n;
            cnt_inc     <= inc_n;
            cnt_field   <= field_n;
            cnt_clr     <= clr_edge;
            running     <= (state_n == S_RUN);
            digit_sel   <= dig_n;
            an          <= an_n;
            disp_hold   <= hold_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the stopwatch control.
module tb_stopwatch_ctrl;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, tick_2hz;
    logic       pause_btn, clr_btn, lap_btn;
    logic       sw_adjust, sw_sel;
    logic       cnt_inc, cnt_clr, running, disp_hold;
    logic [1:0] cnt_field, digit_sel;
    logic [3:0] an;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_run, m_adj, m_sec, m_resume;
    bit pp, cp, lp;
    int m_k;
    logic       e_inc, e_clr, e_run, e_hold;
    logic [1:0] e_field, e_dig;
    logic [3:0] e_an;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_btn(pause_btn), .clr_btn(clr_btn),
        .lap_btn(lap_btn), .sw_adjust(sw_adjust),
        .sw_sel(sw_sel), .cnt_inc(cnt_inc),
        .cnt_field(cnt_field), .cnt_clr(cnt_clr),
        .running(running), .digit_sel(digit_sel),
        .an(an), .disp_hold(disp_hold)
    );

    // Advance model and DUT by one clock with the inputs now applied.
    task automatic step();
        bit pe, ce, le, was_adj, blink, blank;
        if (rst) begin
            m_run = 0; m_adj = 0; m_sec = 0; m_resume = 0;
            m_k = 0;
            e_inc = 0; e_field = 0; e_clr = 0; e_run = 0;
            e_dig = 0; e_an = 4'hF; e_hold = 0;
        end else begin
            pe = pause_btn && !pp;
            ce = clr_btn && !cp;
            le = lap_btn && !lp;
            e_clr = ce;
            e_inc = 0;
            if (!ce) begin
                if (!m_adj && m_run && tick_1hz) begin
                    e_inc = 1; e_field = 2'd0;
                end else if (m_adj && tick_2hz) begin
                    e_inc = 1; e_field = m_sec ? 2'd1 : 2'd2;
                end
            end
            was_adj = m_adj;
            if (ce) begin
                m_adj = 0; m_run = 0; m_resume = 0;
            end else if (sw_adjust) begin
                if (!m_adj) m_resume = m_run;
                m_adj = 1; m_sec = sw_sel; m_run = 0;
            end else if (m_adj) begin
                m_adj = 0; m_run = m_resume;
            end else if (pe) begin
                m_run = !m_run;
            end
            e_run = m_run;
`ifdef STOPWATCH_LAP_EN
            if (le) e_hold = !e_hold;
            if (ce || (!was_adj && m_adj)) e_hold = 0;
`else
            e_hold = 0;
            if (le && was_adj) e_hold = 0;
`endif
            m_k++;
            e_dig = 2'((m_k / SD) % 4);
            blink = ((m_k / BD) % 2) == 0;
            blank = m_adj && !blink &&
                    (m_sec ? (e_dig < 2) : (e_dig >= 2));
            e_an = blank ? 4'hF : ~(4'b0001 << e_dig);
        end
        pp = pause_btn; cp = clr_btn; lp = lap_btn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick_1hz = 0; tick_2hz = 0; pause_btn = 0;
        clr_btn = 0; lap_btn = 0; sw_adjust = 0; sw_sel = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; step(); step();
        rst = 0;
    endtask

    task automatic to_run();
        pause_btn = 1; step();
        pause_btn = 0; step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({cnt_inc, cnt_field, cnt_clr, running} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {cnt_inc, cnt_field, cnt_clr, running});
        end
        total++;
        if (an !== 4'b1111 || digit_sel !== 2'd0 ||
            disp_hold !== 1'b0) begin
            bad++;
            $display("FAIL reset_scan: got an=%b dig=%0d hold=%b",
                     an, digit_sel, disp_hold);
        end
        // button held through reset: no edge afterwards
        pause_btn = 1; rst = 1; step();
        rst = 0; step(); step();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL reset_held_btn: got %b want 0", running);
        end
        // reset kills a pending strobe
        pause_btn = 0; step();
        pause_btn = 1; step();
        tick_1hz = 1; rst = 1; step();
        rst = 0; tick_1hz = 0; pause_btn = 0;
        total++;
        if (cnt_inc !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got inc=%b run=%b want 0 0",
                     cnt_inc, running);
        end
    endtask

    task automatic test_run_count();
        do_reset();
        to_run();
        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1; step();
            tick_1hz = 0;
            total++;
            if (cnt_inc !== 1'b1 || cnt_field !== 2'b00 ||
                running !== 1'b1) begin
                bad++;
                $display("FAIL run_tick%0d: got inc=%b f=%b r=%b",
                         i, cnt_inc, cnt_field, running);
            end
            step();
            total++;
            if (cnt_inc !== 1'b0) begin
                bad++;
                $display("FAIL run_gap%0d: got %b want 0", i, cnt_inc);
            end
        end
    endtask

    task automatic test_pause_tick();
        do_reset();
        to_run();
        pause_btn = 1; tick_1hz = 1; step();
        tick_1hz = 0; pause_btn = 0;
        total++;
        if (cnt_inc !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL pause_tick: got inc=%b r=%b want 1 0",
                     cnt_inc, running);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tick_1hz = 1; step();
            tick_1hz = 0;
            total++;
            if (cnt_inc !== 1'b0) begin
                bad++;
                $display("FAIL paused_tick%0d: got %b want 0",
                         i, cnt_inc);
            end
        end
    endtask

    task automatic test_adjust();
        do_reset();
        to_run();
        sw_adjust = 1; sw_sel = 1; step();
        tick_1hz = 1; step();
        tick_1hz = 0;
        total++;
        if (cnt_inc !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL adj_1hz: got inc=%b r=%b want 0 0",
                     cnt_inc, running);
        end
        tick_2hz = 1; step();
        tick_2hz = 0;
        total++;
        if (cnt_inc !== 1'b1 || cnt_field !== 2'b01) begin
            bad++;
            $display("FAIL adj_sec: got inc=%b f=%b want 1 01",
                     cnt_inc, cnt_field);
        end
        sw_sel = 0; step();
        total++;
        if (cnt_field !== 2'b01) begin
            bad++;
            $display("FAIL adj_hold_field: got %b want 01", cnt_field);
        end
        pause_btn = 1; tick_2hz = 1; step();
        tick_2hz = 0; pause_btn = 0;
        total++;
        if (cnt_inc !== 1'b1 || cnt_field !== 2'b10 ||
            running !== 1'b0) begin
            bad++;
            $display("FAIL adj_min: got inc=%b f=%b r=%b",
                     cnt_inc, cnt_field, running);
        end
        sw_adjust = 0; step();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL adj_resume: got %b want 1", running);
        end
    endtask

    task automatic test_clr_tick();
        do_reset();
        to_run();
        clr_btn = 1; tick_1hz = 1; step();
        tick_1hz = 0;
        total++;
        if (cnt_clr !== 1'b1 || cnt_inc !== 1'b0 ||
            running !== 1'b0) begin
            bad++;
            $display("FAIL clr_tick: got c=%b i=%b r=%b want 1 0 0",
                     cnt_clr, cnt_inc, running);
        end
        step();
        total++;
        if (cnt_clr !== 1'b0) begin
            bad++;
            $display("FAIL clr_width: got %b want 0", cnt_clr);
        end
        clr_btn = 0;
    endtask

    task automatic test_scan_blank();
        int seen_blank;
        seen_blank = 0;
        do_reset();
        sw_adjust = 1; sw_sel = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (an === 4'hF) seen_blank++;
            total++;
            if (an !== e_an || digit_sel !== e_dig) begin
                bad++;
                $display("FAIL scan_%0d: got an=%b d=%0d want %b %0d",
                         i, an, digit_sel, e_an, e_dig);
            end
        end
        total++;
        if (seen_blank == 0) begin
            bad++;
            $display("FAIL scan_blank_seen: got 0 blanked slots");
        end
        idle();
    endtask

    task automatic test_lap();
        do_reset();
        to_run();
        lap_btn = 1; tick_1hz = 1; step();
        tick_1hz = 0; lap_btn = 0;
        total++;
        if (disp_hold !== e_hold || cnt_inc !== 1'b1) begin
            bad++;
            $display("FAIL lap_on: got h=%b i=%b want %b 1",
                     disp_hold, cnt_inc, e_hold);
        end
`ifdef STOPWATCH_LAP_EN
        total++;
        if (disp_hold !== 1'b1) begin
            bad++;
            $display("FAIL lap_on_const: got %b want 1", disp_hold);
        end
`endif
        step();
        lap_btn = 1; step();
        lap_btn = 0;
        total++;
        if (disp_hold !== 1'b0) begin
            bad++;
            $display("FAIL lap_off: got %b want 0", disp_hold);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom % 150) == 0;
            tick_1hz  = ($urandom % 4) == 0;
            tick_2hz  = ($urandom % 3) == 0;
            if ($urandom % 6 == 0)  pause_btn = !pause_btn;
            if ($urandom % 20 == 0) clr_btn   = !clr_btn;
            if ($urandom % 8 == 0)  lap_btn   = !lap_btn;
            if ($urandom % 25 == 0) sw_adjust = !sw_adjust;
            if ($urandom % 10 == 0) sw_sel    = !sw_sel;
            step();
            total++;
            if (cnt_inc !== e_inc || cnt_field !== e_field ||
                cnt_clr !== e_clr || running !== e_run ||
                digit_sel !== e_dig || an !== e_an ||
                disp_hold !== e_hold) begin
                bad++;
                $display("FAIL rand_%0d: got %b%b%b%b%b%b%b want %b%b%b%b%b%b%b",
                         i, cnt_inc, cnt_field, cnt_clr, running,
                         digit_sel, an, disp_hold,
                         e_inc, e_field, e_clr, e_run,
                         e_dig, e_an, e_hold);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_run_count();
        test_pause_tick();
        test_adjust();
        test_clr_tick();
        test_scan_blank();
        test_lap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
